// File: rtl/key_matrix_scanner.sv
// key_matrix_scanner
// Scans a 4x4 active-low key matrix one row at a time, debounces the
// full-scan result and commits a 5-bit key code (5'h10 = no key).
// Optional feature: define KEY_SCAN_AUTOREPEAT_EN to re-pulse key_valid
// every REPEAT_SCANS full scans while the committed key stays held.
module key_matrix_scanner #(
  parameter int SCAN_DIV       = 16,
  parameter int DEBOUNCE_SCANS = 3,
  parameter int REPEAT_SCANS   = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] col_in,
  output logic [3:0] row_out,
  output logic [4:0] key,
  output logic       key_valid,
  output logic       key_down
);

  localparam int DIV_W = $clog2(SCAN_DIV);
  localparam int STB_W = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [4:0]       NO_KEY     = 5'h10;
  localparam logic [DIV_W-1:0] DWELL_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [STB_W-1:0] STB_MAX    = STB_W'(DEBOUNCE_SCANS);

  // Parameter sanity: a row must dwell long enough for the 2-flop synchronizer.
  if (SCAN_DIV < 4 || DEBOUNCE_SCANS < 1 || REPEAT_SCANS < 1) begin : g_param_check
    $error("key_matrix_scanner: SCAN_DIV>=4, DEBOUNCE_SCANS>=1, REPEAT_SCANS>=1 required");
  end

  // Synchronizer holds raw active-low columns; snapshot holds 1 = pressed.
  logic [3:0]       col_s1_q, col_s1_d;
  logic [3:0]       col_s2_q, col_s2_d;
  logic [1:0]       row_q, row_d;
  logic [DIV_W-1:0] dwell_q, dwell_d;
  logic [15:0]      snap_q, snap_d;
  logic             scan_done_q, scan_done_d;
  logic [4:0]       prev_q, prev_d;
  logic [STB_W-1:0] stable_q, stable_d;
  logic [4:0]       key_q, key_d;
  logic             key_down_q, key_down_d;
  logic             key_valid_q, key_valid_d;
  logic [4:0]       result;

`ifdef KEY_SCAN_AUTOREPEAT_EN
  localparam int REP_W = (REPEAT_SCANS > 1) ? $clog2(REPEAT_SCANS) : 1;
  localparam logic [REP_W-1:0] REP_LAST = REP_W'(REPEAT_SCANS - 1);
  logic [REP_W-1:0] rep_q, rep_d;
`endif

  // Priority-encode the completed snapshot: lowest pressed index wins.
  always_comb begin
    result = NO_KEY;
    for (int i = 15; i >= 0; i--) begin
      if (snap_q[i]) result = 5'(i);
    end
  end

  // Next state: row scanning, snapshot capture, debounce and commit.
  always_comb begin
    col_s1_d    = col_in;
    col_s2_d    = col_s1_q;
    row_d       = row_q;
    dwell_d     = dwell_q + 1'b1;
    snap_d      = snap_q;
    scan_done_d = 1'b0;
    prev_d      = prev_q;
    stable_d    = stable_q;
    key_d       = key_q;
    key_down_d  = key_down_q;
    key_valid_d = 1'b0;
`ifdef KEY_SCAN_AUTOREPEAT_EN
    rep_d       = rep_q;
`endif

    if (dwell_q == DWELL_LAST) begin
      dwell_d = '0;
      snap_d[{row_q, 2'b00} +: 4] = ~col_s2_q;
      row_d = row_q + 1'b1;
      scan_done_d = (row_q == 2'd3);
    end

    // The snapshot is complete one cycle after the row-3 sample.
    if (scan_done_q) begin
      if (result == prev_q) begin
        stable_d = (stable_q == STB_MAX) ? stable_q : stable_q + 1'b1;
      end else begin
        stable_d = STB_W'(1);
      end
      prev_d = result;

      if (stable_d == STB_MAX && result != key_q) begin
        key_d       = result;
        key_down_d  = (result != NO_KEY);
        key_valid_d = (result != NO_KEY);
`ifdef KEY_SCAN_AUTOREPEAT_EN
        rep_d       = '0;
`endif
      end
`ifdef KEY_SCAN_AUTOREPEAT_EN
      else if (key_down_q && result == key_q) begin
        if (rep_q == REP_LAST) begin
          rep_d       = '0;
          key_valid_d = 1'b1;
        end else begin
          rep_d = rep_q + 1'b1;
        end
      end
`endif
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      col_s1_q    <= 4'hF;
      col_s2_q    <= 4'hF;
      row_q       <= 2'd0;
      dwell_q     <= '0;
      snap_q      <= 16'h0000;
      scan_done_q <= 1'b0;
      prev_q      <= NO_KEY;
      stable_q    <= '0;
      key_q       <= NO_KEY;
      key_down_q  <= 1'b0;
      key_valid_q <= 1'b0;
`ifdef KEY_SCAN_AUTOREPEAT_EN
      rep_q       <= '0;
`endif
    end else begin
      col_s1_q    <= col_s1_d;
      col_s2_q    <= col_s2_d;
      row_q       <= row_d;
      dwell_q     <= dwell_d;
      snap_q      <= snap_d;
      scan_done_q <= scan_done_d;
      prev_q      <= prev_d;
      stable_q    <= stable_d;
      key_q       <= key_d;
      key_down_q  <= key_down_d;
      key_valid_q <= key_valid_d;
`ifdef KEY_SCAN_AUTOREPEAT_EN
      rep_q       <= rep_d;
`endif
    end
  end

  assign row_out   = ~(4'b0001 << row_q);
  assign key       = key_q;
  assign key_valid = key_valid_q;
  assign key_down  = key_down_q;

endmodule

// File: tb/tb_key_matrix_scanner.sv
// Testbench for key_matrix_scanner (SCAN_DIV=4, DEBOUNCE_SCANS=3).
// A keypad model drives col_in from row_out; expected key_valid pulses
// (code and cycle) are queued by the stimulus and checked by a monitor.
// Define KEY_SCAN_AUTOREPEAT_EN to also expect auto-repeat pulses.
module tb_key_matrix_scanner;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] col_in;
  logic [3:0] row_out;
  logic [4:0] key;
  logic       key_valid;
  logic       key_down;

  logic [15:0] keys = 16'h0000;
  int cyc = 0;
  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [4:0] code;
    int         cyc;
  } exp_t;
  exp_t q[$];

  key_matrix_scanner #(
    .SCAN_DIV(4),
    .DEBOUNCE_SCANS(3),
    .REPEAT_SCANS(5)
  ) dut (
    .clk(clk),
    .rst(rst),
    .col_in(col_in),
    .row_out(row_out),
    .key(key),
    .key_valid(key_valid),
    .key_down(key_down)
  );

  always #5 clk = ~clk;

  // Keypad model: a pressed key pulls its column low while its row is driven.
  always_comb begin
    col_in = 4'hF;
    for (int r = 0; r < 4; r++) begin
      if (!row_out[r]) begin
        for (int c = 0; c < 4; c++) begin
          if (keys[r*4 + c]) col_in[c] = 1'b0;
        end
      end
    end
  end

  // Cycle count since reset release, matching the scan timeline.
  always @(posedge clk) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  // Monitor: row sequencing, key_down consistency and the pulse scoreboard.
  always @(negedge clk) begin
    logic [1:0] er;
    logic [3:0] exp_row;
    exp_t e;
    er = 2'((cyc >> 2) & 3);
    exp_row = ~(4'b0001 << er);
    checks++;
    if (row_out !== exp_row) begin
      failures++;
      $display("FAIL row_out cyc=%0d got %b want %b", cyc, row_out, exp_row);
    end
    checks++;
    if (key_down !== (key != 5'h10)) begin
      failures++;
      $display("FAIL key_down_level cyc=%0d got %b key=%h", cyc, key_down, key);
    end
    if (q.size() != 0 && cyc > q[0].cyc) begin
      e = q.pop_front();
      checks++;
      failures++;
      $display("FAIL missing_pulse got none want code=%h at cyc=%0d", e.code, e.cyc);
    end
    if (key_valid === 1'b1) begin
      checks++;
      if (q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_pulse cyc=%0d got key=%h want no pulse", cyc, key);
      end else begin
        e = q.pop_front();
        if (key !== e.code || cyc != e.cyc || key_down !== 1'b1) begin
          failures++;
          $display("FAIL pulse got key=%h cyc=%0d down=%b want key=%h cyc=%0d down=1",
                   key, cyc, key_down, e.code, e.cyc);
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [4:0] act, input logic [4:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d got %h want %h", nm, cyc, act, exp);
    end
  endtask

  task automatic run_scans(input int n);
    repeat (16*n) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic align();
    while (cyc % 16 != 0) step();
  endtask

  // Press applied at a scan boundary commits after 3 scans + 1 cycle.
  task automatic expect_pulse(input logic [4:0] code, input int delay);
    q.push_back('{code: code, cyc: cyc + delay});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_key", key, 5'h10);
    chk("rst_valid", {4'b0, key_valid}, 5'h00);
    chk("rst_down", {4'b0, key_down}, 5'h00);
    chk("rst_row", {1'b0, row_out}, 5'h0E);
    rst = 1'b0;

    // Idle scanning
    run_scans(2);
    chk("idle_key", key, 5'h10);
    chk("idle_down", {4'b0, key_down}, 5'h00);

    // Hold code 9 from a scan start
    keys = 16'h0001 << 9;
    expect_pulse(5'h09, 49);
`ifdef KEY_SCAN_AUTOREPEAT_EN
    expect_pulse(5'h09, 49 + 80);
    expect_pulse(5'h09, 49 + 160);
`endif
    run_scans(3);
    chk("k9_before_commit", key, 5'h10);
    step();
    chk("k9_commit", key, 5'h09);
    chk("k9_down", {4'b0, key_down}, 5'h01);
    align();
    run_scans(9);
    chk("k9_held", key, 5'h09);

    // Release
    keys = 16'h0000;
    run_scans(3);
    chk("rel_before_commit", key, 5'h09);
    step();
    chk("rel_key", key, 5'h10);
    chk("rel_down", {4'b0, key_down}, 5'h00);
    align();

    // Bounce on alternate scans
    for (int i = 0; i < 8; i++) begin
      keys = (i % 2 == 0) ? (16'h0001 << 9) : 16'h0000;
      run_scans(1);
    end
    keys = 16'h0000;
    run_scans(2);
    chk("bounce_key", key, 5'h10);
    chk("bounce_down", {4'b0, key_down}, 5'h00);

    // Two keys: lowest code wins, then direct change to the other
    keys = (16'h0001 << 7) | (16'h0001 << 8);
    expect_pulse(5'h07, 49);
    run_scans(3);
    step();
    chk("multi_key", key, 5'h07);
    align();
    keys = 16'h0001 << 8;
    expect_pulse(5'h08, 49);
    run_scans(3);
    chk("change_before", key, 5'h07);
    step();
    chk("change_key", key, 5'h08);
    chk("change_down", {4'b0, key_down}, 5'h01);
    align();

    // Release after commit
    keys = 16'h0000;
    run_scans(3);
    step();
    chk("rel2_key", key, 5'h10);
    chk("rel2_down", {4'b0, key_down}, 5'h00);
    align();

    // Reset mid-debounce of a new press
    keys = 16'h0001 << 3;
    repeat (24) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_key", key, 5'h10);
    chk("midrst_valid", {4'b0, key_valid}, 5'h00);
    chk("midrst_down", {4'b0, key_down}, 5'h00);
    chk("midrst_row", {1'b0, row_out}, 5'h0E);
    rst = 1'b0;
    expect_pulse(5'h03, 49);
    run_scans(3);
    chk("midrst_before", key, 5'h10);
    step();
    chk("midrst_commit", key, 5'h03);
    align();
    keys = 16'h0000;
    run_scans(3);
    step();
    chk("final_rel", key, 5'h10);
    run_scans(1);

    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL pending_pulses got %0d outstanding want 0", q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
